// File: rtl/sgray_counter_pkg.sv
// Shared encodings and Gray/binary conversion helpers for the sgray counter family.
// Helpers work on a fixed-width word; callers zero-extend in and truncate out.
package sgray_pkg;

  localparam int MAX_LEN = 64;
  typedef logic [MAX_LEN-1:0] word_t;

  // Overflow behaviour encodings.
  localparam int WRAP = 0;
  localparam int SAT  = 1;

  // Load value encodings.
  localparam int LOAD_BIN  = 0;
  localparam int LOAD_GRAY = 1;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits leave the running XOR untouched, so any LEN <= MAX_LEN works.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[MAX_LEN-1] = g[MAX_LEN-1];
    for (int i = MAX_LEN - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sgray_counter_if.sv
// Control and status bundle for sgray_counter; the counter takes the slave side.
interface sgray_counter_if #(
  parameter int LEN = 8
);
  logic           clr;
  logic           load;
  logic [LEN-1:0] load_val;
  logic           en;
  logic           up;
  logic [LEN-1:0] bin;
  logic [LEN-1:0] gray;
  logic           ovf;

  modport master (
    output clr, load, load_val, en, up,
    input  bin, gray, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output bin, gray, ovf
  );
endinterface

// File: rtl/sgray_to_bin_comb.sv
// Purely combinational Gray-to-binary decoder; bit i is the XOR of gray[LEN-1:i].
module sgray_to_bin_comb #(
  parameter int LEN = 8
) (
  input  logic [LEN-1:0] gray,
  output logic [LEN-1:0] bin
);

  // Each bit is an independent reduction, which keeps the netlist free of
  // a combinational chain through bin itself.
  for (genvar i = 0; i < LEN; i++) begin : g_bit
    assign bin[i] = ^gray[LEN-1:i];
  end

endmodule

// File: rtl/sgray_counter.sv
// Up/down counter with separately registered binary and Gray outputs,
// synchronous clear/load, wrap or saturate mode and a one-cycle overflow flag.
module sgray_counter #(
  parameter int             LEN       = 8,
  parameter int             SATURATE  = 0,
  parameter int             LOAD_GRAY = 0,
  parameter logic [LEN-1:0] RST_VAL   = '0
) (
  input logic             CLK,
  input logic             RST,
  sgray_counter_if.slave  bus
);
  import sgray_pkg::*;

  localparam logic [LEN-1:0] MAX_VAL  = '1;
  localparam logic [LEN-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);
  localparam bit             SAT_MODE = (SATURATE == sgray_pkg::SAT);
  localparam bit             GRAY_LD  = (LOAD_GRAY == sgray_pkg::LOAD_GRAY);

  logic [LEN-1:0] bin_q;
  logic [LEN-1:0] gray_q;
  logic           ovf_q;

  logic [LEN-1:0] load_dec;
  logic [LEN-1:0] load_bin;
  logic [LEN-1:0] next_bin;
  logic [LEN-1:0] next_gray;
  logic           next_ovf;

  sgray_to_bin_comb #(
    .LEN (LEN)
  ) u_load_dec (
    .gray (bus.load_val),
    .bin  (load_dec)
  );

  assign load_bin = GRAY_LD ? load_dec : bus.load_val;

  // Priority: clr > load > en > hold.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    next_bin = bin_q;
    next_ovf = 1'b0;
    if (bus.clr) begin
      next_bin = RST_VAL;
    end else if (bus.load) begin
      next_bin = load_bin;
    end else if (bus.en) begin
      if (bus.up) begin
        if (bin_q == MAX_VAL) begin
          next_ovf = 1'b1;
          next_bin = SAT_MODE ? bin_q : '0;
        end else begin
          next_bin = bin_q + LEN'(1);
        end
      end else begin
        if (bin_q == '0) begin
          next_ovf = 1'b1;
          next_bin = SAT_MODE ? '0 : MAX_VAL;
        end else begin
          next_bin = bin_q - LEN'(1);
        end
      end
    end
  end

  // Gray is encoded from the next value, not from bin_q, so the Gray register
  // is loaded in the same edge and toggles one bit per count step.
  assign next_gray = LEN'(bin2gray(word_t'(next_bin)));

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      bin_q  <= RST_VAL;
      gray_q <= RST_GRAY;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= next_gray;
      ovf_q  <= next_ovf;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.gray = gray_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_sgray_counter.sv
// Directed plus random checks of four sgray_counter configurations against a
// behavioural model, with expectations queued at drive time and popped after the edge.
module tb_sgray_counter;

  typedef struct {
    int          dut;
    logic [31:0] bin;
    logic [31:0] gray;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // Configurations: 0 = wrap, 1 = saturate, 2 = Gray load, 3 = 8-bit with RST_VAL 0x80.
  int p_len [4] = '{4, 4, 4, 8};
  int p_sat [4] = '{0, 1, 0, 0};
  int p_lg  [4] = '{0, 0, 1, 0};
  int p_rst [4] = '{0, 0, 0, 'h80};

  logic       c_clr [4];
  logic       c_load[4];
  logic       c_en  [4];
  logic       c_up  [4];
  logic [7:0] c_ld  [4];

  int m_bin[4];
  bit m_ovf[4];

  logic [7:0] obs_bin [4];
  logic [7:0] obs_gray[4];
  logic       obs_ovf [4];

  sgray_counter_if #(.LEN(4)) if0 ();
  sgray_counter_if #(.LEN(4)) if1 ();
  sgray_counter_if #(.LEN(4)) if2 ();
  sgray_counter_if #(.LEN(8)) if3 ();

  assign if0.clr = c_clr[0]; assign if0.load = c_load[0]; assign if0.en = c_en[0];
  assign if0.up  = c_up[0];  assign if0.load_val = c_ld[0][3:0];
  assign if1.clr = c_clr[1]; assign if1.load = c_load[1]; assign if1.en = c_en[1];
  assign if1.up  = c_up[1];  assign if1.load_val = c_ld[1][3:0];
  assign if2.clr = c_clr[2]; assign if2.load = c_load[2]; assign if2.en = c_en[2];
  assign if2.up  = c_up[2];  assign if2.load_val = c_ld[2][3:0];
  assign if3.clr = c_clr[3]; assign if3.load = c_load[3]; assign if3.en = c_en[3];
  assign if3.up  = c_up[3];  assign if3.load_val = c_ld[3];

  assign obs_bin[0] = {4'h0, if0.bin}; assign obs_gray[0] = {4'h0, if0.gray}; assign obs_ovf[0] = if0.ovf;
  assign obs_bin[1] = {4'h0, if1.bin}; assign obs_gray[1] = {4'h0, if1.gray}; assign obs_ovf[1] = if1.ovf;
  assign obs_bin[2] = {4'h0, if2.bin}; assign obs_gray[2] = {4'h0, if2.gray}; assign obs_ovf[2] = if2.ovf;
  assign obs_bin[3] = if3.bin;         assign obs_gray[3] = if3.gray;         assign obs_ovf[3] = if3.ovf;

  sgray_counter #(.LEN(4), .SATURATE(0), .LOAD_GRAY(0), .RST_VAL(4'h0))
    u_wrap4 (.CLK(CLK), .RST(RST), .bus(if0));
  sgray_counter #(.LEN(4), .SATURATE(1), .LOAD_GRAY(0), .RST_VAL(4'h0))
    u_sat4  (.CLK(CLK), .RST(RST), .bus(if1));
  sgray_counter #(.LEN(4), .SATURATE(0), .LOAD_GRAY(1), .RST_VAL(4'h0))
    u_lg4   (.CLK(CLK), .RST(RST), .bus(if2));
  sgray_counter #(.LEN(8), .SATURATE(0), .LOAD_GRAY(0), .RST_VAL(8'h80))
    u_rv8   (.CLK(CLK), .RST(RST), .bus(if3));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int g2b(input int g, input int len);
    int r   = 0;
    bit acc = 1'b0;
    for (int i = len - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      r[i] = acc;
    end
    return r;
  endfunction

  function automatic void model_step(input int d);
    int mx = (1 << p_len[d]) - 1;
    int ld = int'(c_ld[d]) & mx;
    m_ovf[d] = 1'b0;
    if (RST || c_clr[d]) begin
      m_bin[d] = p_rst[d];
    end else if (c_load[d]) begin
      m_bin[d] = (p_lg[d] != 0) ? g2b(ld, p_len[d]) : ld;
    end else if (c_en[d]) begin
      if (c_up[d]) begin
        if (m_bin[d] == mx) begin
          m_ovf[d] = 1'b1;
          m_bin[d] = (p_sat[d] != 0) ? mx : 0;
        end else m_bin[d] = m_bin[d] + 1;
      end else begin
        if (m_bin[d] == 0) begin
          m_ovf[d] = 1'b1;
          m_bin[d] = (p_sat[d] != 0) ? 0 : mx;
        end else m_bin[d] = m_bin[d] - 1;
      end
    end
  endfunction

  task automatic push_state();
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.dut  = d;
      e.bin  = m_bin[d];
      e.gray = m_bin[d] ^ (m_bin[d] >> 1);
      e.ovf  = m_ovf[d];
      sb.push_back(e);
    end
  endtask

  task automatic compare_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("d%0d_bin", e.dut),  {24'h0, obs_bin[e.dut]},  e.bin);
      check($sformatf("d%0d_gray", e.dut), {24'h0, obs_gray[e.dut]}, e.gray);
      check($sformatf("d%0d_ovf", e.dut),  {31'h0, obs_ovf[e.dut]},  {31'h0, e.ovf});
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    for (int d = 0; d < 4; d++) model_step(d);
    push_state();
    @(posedge CLK);
    #1;
    compare_all();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 4; d++) begin
      c_clr[d] = 1'b0; c_load[d] = 1'b0; c_en[d] = 1'b0; c_up[d] = 1'b0; c_ld[d] = 8'h00;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_bin[d] = p_rst[d];
      m_ovf[d] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] prev_gray;

    // Reset held across edges: all configurations sit at their reset values.
    RST = 1'b1;
    idle_inputs();
    model_reset();
    c_en[0] = 1'b1; c_up[0] = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    push_state();
    compare_all();
    RST = 1'b0;
    idle_inputs();

    // Wrap mode: full up-count cycle with one-bit Gray steps and ovf on 15->0.
    c_en[0] = 1'b1; c_up[0] = 1'b1;
    prev_gray = obs_gray[0];
    for (int i = 0; i < 17; i++) begin
      step();
      check("wrap_gray_onebit", $countones(obs_gray[0] ^ prev_gray), 1);
      prev_gray = obs_gray[0];
      if (i == 15) begin
        check("wrap_bin_at_wrap", {24'h0, obs_bin[0]}, 32'h0);
        check("wrap_ovf_at_wrap", {31'h0, obs_ovf[0]}, 32'h1);
      end
    end
    idle_inputs();

    // Saturate mode: load 14, count into the ceiling, then down onto the floor.
    c_load[1] = 1'b1; c_ld[1] = 8'd14;
    step();
    c_load[1] = 1'b0; c_en[1] = 1'b1; c_up[1] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("sat_hold_top_bin", {24'h0, obs_bin[1]}, 32'hF);
    check("sat_hold_top_ovf", {31'h0, obs_ovf[1]}, 32'h1);
    c_up[1] = 1'b0;
    for (int i = 0; i < 16; i++) step();
    check("sat_hold_zero_bin", {24'h0, obs_bin[1]}, 32'h0);
    check("sat_hold_zero_ovf", {31'h0, obs_ovf[1]}, 32'h1);
    idle_inputs();

    // Gray-encoded load values are decoded before loading.
    c_load[2] = 1'b1; c_ld[2] = 8'h0C;
    step();
    check("lg_c_bin",  {24'h0, obs_bin[2]},  32'h8);
    check("lg_c_gray", {24'h0, obs_gray[2]}, 32'hC);
    c_ld[2] = 8'h0B;
    step();
    check("lg_b_bin",  {24'h0, obs_bin[2]},  32'hD);
    check("lg_b_gray", {24'h0, obs_gray[2]}, 32'hB);
    idle_inputs();

    // Priority: clr beats load and en; load beats en.
    c_clr[0] = 1'b1; c_load[0] = 1'b1; c_en[0] = 1'b1; c_up[0] = 1'b1; c_ld[0] = 8'd9;
    step();
    check("prio_clr_bin", {24'h0, obs_bin[0]}, 32'h0);
    check("prio_clr_ovf", {31'h0, obs_ovf[0]}, 32'h0);
    c_clr[0] = 1'b0;
    step();
    check("prio_load_bin", {24'h0, obs_bin[0]}, 32'h9);
    idle_inputs();

    // Non-zero reset value: count to 0x85, then an asynchronous reset mid-cycle.
    c_clr[3] = 1'b1;
    step();
    c_clr[3] = 1'b0; c_en[3] = 1'b1; c_up[3] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("rv8_count_bin", {24'h0, obs_bin[3]}, 32'h85);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    push_state();
    compare_all();
    check("rv8_async_bin",  {24'h0, obs_bin[3]},  32'h80);
    check("rv8_async_gray", {24'h0, obs_gray[3]}, 32'hC0);
    @(negedge CLK);
    step();
    RST = 1'b0;
    step();
    check("rv8_resume_bin", {24'h0, obs_bin[3]}, 32'h81);
    idle_inputs();

    // Random soak across all four configurations.
    for (int i = 0; i < 10000; i++) begin
      for (int d = 0; d < 4; d++) begin
        c_clr[d]  = ($urandom_range(31) == 0);
        c_load[d] = ($urandom_range(15) == 0);
        c_en[d]   = ($urandom_range(3) != 0);
        c_up[d]   = $urandom_range(1) != 0;
        c_ld[d]   = 8'($urandom_range(255));
      end
      step();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
